// File: rtl/watch_mode_controller_if.sv
// Panel-side bundle for the watch mode controller: debounced buttons and live time in,
// watch control pulses, edit registers and display qualifiers out.
interface watch_mode_controller_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_startstop;
  logic       btn_clear;
  logic [3:0] cur_hr1;
  logic [3:0] cur_hr0;
  logic [3:0] cur_min1;
  logic [3:0] cur_min0;
  logic       start_resume;
  logic       stop;
  logic       watch_reset;
  logic       set_time;
  logic [3:0] set_hr1;
  logic [3:0] set_hr0;
  logic [3:0] set_min1;
  logic [3:0] set_min0;
  logic       blink_hr;
  logic       blink_min;
  logic       running;
  logic [1:0] mode;

  modport master (
    output btn_mode, btn_inc, btn_startstop, btn_clear,
    output cur_hr1, cur_hr0, cur_min1, cur_min0,
    input  start_resume, stop, watch_reset, set_time,
    input  set_hr1, set_hr0, set_min1, set_min0,
    input  blink_hr, blink_min, running, mode
  );

  modport slave (
    input  btn_mode, btn_inc, btn_startstop, btn_clear,
    input  cur_hr1, cur_hr0, cur_min1, cur_min0,
    output start_resume, stop, watch_reset, set_time,
    output set_hr1, set_hr0, set_min1, set_min0,
    output blink_hr, blink_min, running, mode
  );
endinterface

// File: rtl/watch_mode_controller.sv
// Front-panel sequencer: turns button edges into watch run/stop/clear controls and
// edits an hour/minute copy of the time, committed with a single set_time strobe.
module watch_mode_controller #(
  parameter int unsigned HOUR_MAX  = 23,
  parameter int unsigned BLINK_DIV = 25000000,
  parameter int unsigned TIMEOUT   = 500000000
) (
  input logic clk,
  input logic reset,
  watch_mode_controller_if.slave bus
);
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Pulse vector order: {start_resume, stop, watch_reset, set_time}
  localparam logic [3:0] P_START  = 4'b1000;
  localparam logic [3:0] P_STOP   = 4'b0100;
  localparam logic [3:0] P_WRESET = 4'b0010;
  localparam logic [3:0] P_SET    = 4'b0001;

  typedef enum logic [2:0] {
    S_PAUSED, S_RUN, S_SET_HR, S_SET_MIN, S_COMMIT, S_RESUME
  } state_t;

  state_t          r_state, w_state;
  logic [3:0]      r_btn_q, w_btn, w_edge;
  logic            w_clr, w_md, w_ss, w_inc;
  logic [15:0]     r_edit, w_edit, w_cur;
  logic            r_resume, w_resume;
  logic [3:0]      r_pulse, w_pulse;
  logic [BW-1:0]   r_blink_cnt, w_blink_cnt;
  logic            r_phase, w_phase;
  logic [TW-1:0]   r_idle, w_idle;
  logic            w_timeout, w_acc_inc, w_in_edit, w_restart;
  logic [1:0]      w_mode;

  // Out-of-range or non-BCD values restart the field at 00.
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones,
                                         input int unsigned max);
    int unsigned v;
    v = 32'(tens) * 32'd10 + 32'(ones);
    if (tens > 4'd9 || ones > 4'd9 || v >= max) return 8'h00;
    if (ones == 4'd9) return {tens + 4'd1, 4'd0};
    return {tens, ones + 4'd1};
  endfunction

  assign w_btn  = {bus.btn_clear, bus.btn_mode, bus.btn_startstop, bus.btn_inc};
  assign w_edge = w_btn & ~r_btn_q;
  assign w_clr  = w_edge[3];
  assign w_md   = w_edge[2] & ~w_edge[3];
  assign w_ss   = w_edge[1] & ~|w_edge[3:2];
  assign w_inc  = w_edge[0] & ~|w_edge[3:1];
  assign w_cur  = {bus.cur_hr1, bus.cur_hr0, bus.cur_min1, bus.cur_min0};

  always_comb begin
    w_state   = r_state;
    w_edit    = r_edit;
    w_resume  = r_resume;
    w_pulse   = '0;
    w_acc_inc = 1'b0;
    w_timeout = (r_idle == TW'(TIMEOUT - 1));
    if (w_clr) begin
      w_state  = S_PAUSED;
      w_edit   = '0;
      w_resume = 1'b0;
      w_pulse  = P_WRESET;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_md) begin
            w_state  = S_SET_HR;
            w_edit   = w_cur;
            w_resume = 1'b1;
            w_pulse  = P_STOP;
          end else if (w_ss) begin
            w_state = S_PAUSED;
            w_pulse = P_STOP;
          end
        end
        S_PAUSED: begin
          if (w_md) begin
            w_state  = S_SET_HR;
            w_edit   = w_cur;
            w_resume = 1'b0;
          end else if (w_ss) begin
            w_state = S_RUN;
            w_pulse = P_START;
          end
        end
        S_SET_HR: begin
          if (w_md) begin
            w_state = S_SET_MIN;
          end else if (w_inc) begin
            w_edit[15:8] = bcd_inc(r_edit[15:12], r_edit[11:8], HOUR_MAX);
            w_acc_inc    = 1'b1;
          end else if (w_timeout) begin
            w_state = r_resume ? S_RESUME : S_PAUSED;
            w_pulse = r_resume ? P_START : '0;
          end
        end
        S_SET_MIN: begin
          if (w_md) begin
            w_state = S_COMMIT;
            w_pulse = P_SET;
          end else if (w_inc) begin
            w_edit[7:0] = bcd_inc(r_edit[7:4], r_edit[3:0], 59);
            w_acc_inc   = 1'b1;
          end else if (w_timeout) begin
            w_state = r_resume ? S_RESUME : S_PAUSED;
            w_pulse = r_resume ? P_START : '0;
          end
        end
        S_COMMIT: begin
          w_state = r_resume ? S_RESUME : S_PAUSED;
          w_pulse = r_resume ? P_START : '0;
        end
        S_RESUME: w_state = S_RUN;
        default:  w_state = S_PAUSED;
      endcase
    end

    // Blink and idle timers share one restart condition: edit-state entry or an accepted inc.
    w_in_edit   = (w_state == S_SET_HR) || (w_state == S_SET_MIN);
    w_restart   = (w_state != r_state) || w_acc_inc;
    w_idle      = '0;
    w_blink_cnt = '0;
    w_phase     = 1'b0;
    if (w_in_edit && !w_restart) begin
      w_idle = r_idle + TW'(1);
      if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
        w_phase = ~r_phase;
      end else begin
        w_blink_cnt = r_blink_cnt + BW'(1);
        w_phase     = r_phase;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_PAUSED;
      r_btn_q     <= '0;
      r_edit      <= '0;
      r_resume    <= 1'b0;
      r_pulse     <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_idle      <= '0;
    end else begin
      r_state     <= w_state;
      r_btn_q     <= w_btn;
      r_edit      <= w_edit;
      r_resume    <= w_resume;
      r_pulse     <= w_pulse;
      r_blink_cnt <= w_blink_cnt;
      r_phase     <= w_phase;
      r_idle      <= w_idle;
    end
  end

  always_comb begin
    case (r_state)
      S_SET_HR:           w_mode = 2'd1;
      S_SET_MIN:          w_mode = 2'd2;
      S_COMMIT, S_RESUME: w_mode = 2'd3;
      default:            w_mode = 2'd0;
    endcase
  end

  assign bus.start_resume = r_pulse[3];
  assign bus.stop         = r_pulse[2];
  assign bus.watch_reset  = r_pulse[1];
  assign bus.set_time     = r_pulse[0];
  assign bus.set_hr1      = r_edit[15:12];
  assign bus.set_hr0      = r_edit[11:8];
  assign bus.set_min1     = r_edit[7:4];
  assign bus.set_min0     = r_edit[3:0];
  assign bus.blink_hr     = r_phase & (r_state == S_SET_HR);
  assign bus.blink_min    = r_phase & (r_state == S_SET_MIN);
  assign bus.running      = (r_state == S_RUN);
  assign bus.mode         = w_mode;
endmodule

// File: tb/tb_watch_mode_controller.sv
// Bench for watch_mode_controller: directed button sequences, a time/phase model checked
// every cycle, and literal expectations at the key points of each sequence.
module tb_watch_mode_controller;
  localparam int unsigned HMAX = 23;
  localparam int unsigned BDIV = 4;
  localparam int unsigned TOUT = 100;

  localparam int M_PAUSED = 0, M_RUN = 1, M_SETHR = 2, M_SETMIN = 3, M_COMMIT = 4, M_RESUME = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  watch_mode_controller_if bus();

  watch_mode_controller #(.HOUR_MAX(HMAX), .BLINK_DIV(BDIV), .TIMEOUT(TOUT)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Model: phase of the panel, time as integers, cycles since edit entry / last accepted inc.
  int         m_st, m_hr, m_mn, m_since, m_sel;
  logic [7:0] m_hraw, m_mraw;
  bit         m_hok, m_mok, m_resume, m_live = 1'b0;
  logic [3:0] m_pulse, m_prev, m_b, m_e;
  int         m_nst;
  bit         m_acc;

  task automatic m_capture();
    m_hraw = {bus.cur_hr1, bus.cur_hr0};
    m_mraw = {bus.cur_min1, bus.cur_min0};
    m_hok  = (bus.cur_hr1 <= 4'd9) && (bus.cur_hr0 <= 4'd9);
    m_mok  = (bus.cur_min1 <= 4'd9) && (bus.cur_min0 <= 4'd9);
    m_hr   = 32'(bus.cur_hr1) * 10 + 32'(bus.cur_hr0);
    m_mn   = 32'(bus.cur_min1) * 10 + 32'(bus.cur_min0);
  endtask

  task automatic m_leave_edit();
    m_nst   = m_resume ? M_RESUME : M_PAUSED;
    m_pulse = m_resume ? 4'b1000 : 4'b0000;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_st = M_PAUSED; m_hr = 0; m_mn = 0; m_hok = 1'b1; m_mok = 1'b1;
      m_hraw = '0; m_mraw = '0; m_resume = 1'b0; m_since = 0;
      m_pulse = '0; m_prev = '0; m_live = 1'b1;
    end else begin
      m_b = {bus.btn_clear, bus.btn_mode, bus.btn_startstop, bus.btn_inc};
      m_e = m_b & ~m_prev;
      m_prev = m_b;
      m_sel = m_e[3] ? 3 : m_e[2] ? 2 : m_e[1] ? 1 : m_e[0] ? 0 : -1;
      m_nst = m_st; m_pulse = '0; m_acc = 1'b0;
      if (m_sel == 3) begin
        m_nst = M_PAUSED; m_pulse = 4'b0010; m_resume = 1'b0;
        m_hr = 0; m_mn = 0; m_hok = 1'b1; m_mok = 1'b1;
      end else begin
        case (m_st)
          M_RUN:
            if (m_sel == 2) begin m_nst = M_SETHR; m_pulse = 4'b0100; m_capture(); m_resume = 1'b1; end
            else if (m_sel == 1) begin m_nst = M_PAUSED; m_pulse = 4'b0100; end
          M_PAUSED:
            if (m_sel == 2) begin m_nst = M_SETHR; m_capture(); m_resume = 1'b0; end
            else if (m_sel == 1) begin m_nst = M_RUN; m_pulse = 4'b1000; end
          M_SETHR:
            if (m_sel == 2) m_nst = M_SETMIN;
            else if (m_sel == 0) begin
              m_hr = (!m_hok || m_hr >= HMAX) ? 0 : m_hr + 1; m_hok = 1'b1; m_acc = 1'b1;
            end else if (m_since == TOUT - 1) m_leave_edit();
          M_SETMIN:
            if (m_sel == 2) begin m_nst = M_COMMIT; m_pulse = 4'b0001; end
            else if (m_sel == 0) begin
              m_mn = (!m_mok || m_mn >= 59) ? 0 : m_mn + 1; m_mok = 1'b1; m_acc = 1'b1;
            end else if (m_since == TOUT - 1) m_leave_edit();
          M_COMMIT: m_leave_edit();
          default:  m_nst = M_RUN;
        endcase
      end
      if ((m_nst == M_SETHR || m_nst == M_SETMIN) && m_nst == m_st && !m_acc) m_since = m_since + 1;
      else m_since = 0;
      m_st = m_nst;
    end
  end

  function automatic logic [15:0] exp_edit();
    logic [7:0] h, m;
    h = m_hok ? {4'(m_hr / 10), 4'(m_hr % 10)} : m_hraw;
    m = m_mok ? {4'(m_mn / 10), 4'(m_mn % 10)} : m_mraw;
    return {h, m};
  endfunction

  function automatic logic [15:0] exp_status();
    logic [1:0] md;
    bit ph;
    ph = ((m_since / BDIV) % 2) == 1;
    md = (m_st == M_SETHR) ? 2'd1 : (m_st == M_SETMIN) ? 2'd2 :
         (m_st == M_COMMIT || m_st == M_RESUME) ? 2'd3 : 2'd0;
    return {11'd0, m_st == M_RUN, md, ph && m_st == M_SETHR, ph && m_st == M_SETMIN};
  endfunction

  always @(negedge clk) begin
    if (m_live) begin
      chk("pulses", {12'd0, bus.start_resume, bus.stop, bus.watch_reset, bus.set_time}, {12'd0, m_pulse});
      chk("status", {11'd0, bus.running, bus.mode, bus.blink_hr, bus.blink_min}, exp_status());
      chk("edit", {bus.set_hr1, bus.set_hr0, bus.set_min1, bus.set_min0}, exp_edit());
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // {clear, mode, startstop, inc}; returns in the cycle showing the registered result.
  task automatic press(input logic [3:0] m);
    step(1);
    {bus.btn_clear, bus.btn_mode, bus.btn_startstop, bus.btn_inc} = m;
    step(1);
    {bus.btn_clear, bus.btn_mode, bus.btn_startstop, bus.btn_inc} = 4'b0000;
  endtask

  task automatic set_cur(input logic [15:0] t);
    {bus.cur_hr1, bus.cur_hr0, bus.cur_min1, bus.cur_min0} = t;
  endtask

  function automatic logic [3:0] pulses();
    return {bus.start_resume, bus.stop, bus.watch_reset, bus.set_time};
  endfunction

  function automatic logic [15:0] edit();
    return {bus.set_hr1, bus.set_hr0, bus.set_min1, bus.set_min0};
  endfunction

  task automatic idle_len(input string nm, input int req);
    int n;
    n = 0;
    while (bus.mode == 2'd1 && n < 300) begin n++; step(1); end
    chk(nm, 16'(n), 16'(req));
  endtask

  localparam logic [3:0] B_CLR = 4'b1000, B_MODE = 4'b0100, B_SS = 4'b0010, B_INC = 4'b0001;

  initial begin
    {bus.btn_clear, bus.btn_mode, bus.btn_startstop, bus.btn_inc} = 4'b0000;
    set_cur(16'h0000);
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    chk("reset_mode", {14'd0, bus.mode}, 16'd0);
    chk("reset_edit", edit(), 16'h0000);
    chk("reset_pulses", {12'd0, pulses()}, 16'd0);

    press(B_SS);
    chk("start_pulse", {12'd0, pulses()}, 16'h8);
    chk("running_on", {15'd0, bus.running}, 16'd1);
    step(1);
    chk("start_one_cycle", {12'd0, pulses()}, 16'h0);
    press(B_SS);
    chk("stop_pulse", {12'd0, pulses()}, 16'h4);
    chk("running_off", {15'd0, bus.running}, 16'd0);

    set_cur(16'h1045);
    press(B_SS);
    press(B_MODE);
    chk("enter_stop", {12'd0, pulses()}, 16'h4);
    chk("enter_capture", edit(), 16'h1045);
    for (int i = 0; i < 3; i++) press(B_INC);
    press(B_MODE);
    for (int i = 0; i < 20; i++) press(B_INC);
    press(B_MODE);
    chk("commit_strobe", {12'd0, pulses()}, 16'h1);
    chk("commit_value", edit(), 16'h1305);
    step(1);
    chk("resume_pulse", {12'd0, pulses()}, 16'h8);
    step(1);
    chk("resumed_run", {15'd0, bus.running}, 16'd1);

    set_cur(16'h2258);
    press(B_MODE);
    press(B_INC); press(B_INC);
    chk("hour_wrap", edit(), 16'h0058);
    press(B_MODE);
    for (int i = 0; i < 3; i++) press(B_INC);
    chk("minute_wrap", edit(), 16'h0001);
    press(B_CLR | B_MODE);
    chk("clear_wins", {12'd0, pulses()}, 16'h2);
    chk("clear_mode", {14'd0, bus.mode}, 16'd0);
    chk("clear_edit", edit(), 16'h0000);

    set_cur(16'h0730);
    press(B_MODE);
    chk("paused_entry_nopulse", {12'd0, pulses()}, 16'h0);
    press(B_MODE | B_INC);
    chk("mode_over_inc_mode", {14'd0, bus.mode}, 16'd2);
    chk("mode_over_inc_hour", edit(), 16'h0730);
    press(B_CLR);

    press(B_SS);
    press(B_MODE);
    idle_len("timeout_len_run", TOUT);
    chk("timeout_resume", {12'd0, pulses()}, 16'h8);
    chk("timeout_resume_mode", {14'd0, bus.mode}, 16'd3);
    step(1);
    chk("timeout_back_run", {15'd0, bus.running}, 16'd1);

    press(B_SS);
    press(B_MODE);
    idle_len("timeout_len_paused", TOUT);
    chk("timeout_paused_pulses", {12'd0, pulses()}, 16'h0);
    chk("timeout_paused_mode", {14'd0, bus.mode}, 16'd0);

    set_cur(16'h0500);
    press(B_MODE);
    step(4);
    chk("blink_on", {14'd0, bus.blink_hr, bus.blink_min}, 16'b10);
    press(B_INC);
    chk("blink_inc_clear", {15'd0, bus.blink_hr}, 16'd0);
    chk("blink_inc_value", edit(), 16'h0600);
    step(1);
    bus.btn_inc = 1'b1;
    step(50);
    bus.btn_inc = 1'b0;
    step(1);
    chk("held_inc_once", edit(), 16'h0700);
    press(B_CLR);

    set_cur(16'h257C);
    press(B_MODE);
    chk("raw_capture", edit(), 16'h257C);
    press(B_INC);
    chk("bad_hour_inc", edit(), 16'h007C);
    press(B_MODE);
    press(B_INC);
    chk("bad_min_inc", edit(), 16'h0000);
    press(B_MODE);
    chk("paused_commit", {12'd0, pulses()}, 16'h1);
    step(1);
    chk("paused_commit_after", {12'd0, pulses()}, 16'h0);
    chk("paused_commit_mode", {14'd0, bus.mode}, 16'd0);

    press(B_MODE);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk("midedit_reset_mode", {14'd0, bus.mode}, 16'd0);
    chk("midedit_reset_edit", edit(), 16'h0000);
    step(1);
    chk("midedit_reset_pulses", {12'd0, pulses()}, 16'h0);

    bus.btn_startstop = 1'b1;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    chk("held_through_reset", {12'd0, pulses()}, 16'h8);
    bus.btn_startstop = 1'b0;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
